// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote collector.
package vote_pkg;

  localparam int unsigned NUM_VOTERS = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } vote_state_t;

  function automatic logic vote_id_legal(input logic [2:0] id);
    return (id >= 3'd1) && (id <= 3'd5);
  endfunction

endpackage

// File: rtl/vote_collector_if.sv
// Vote input and assembled-vector output handshakes of the vote collector.
// Stats ports exist only when VOTE_COLLECTOR_STATS_EN is defined.
interface vote_collector_if;
  import vote_pkg::*;

  logic                  vote_valid;
  logic [2:0]            vote_id;
  logic                  vote_val;
  logic                  vote_ready;
  logic [NUM_VOTERS:1]   x_out;
  logic [NUM_VOTERS:1]   missing_mask;
  logic                  timed_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  dup_err;
  logic                  bad_id;
`ifdef VOTE_COLLECTOR_STATS_EN
  logic [15:0]           round_cnt;
  logic [15:0]           timeout_cnt;

  // master: voters + downstream consumer; slave: the collector
  modport master (
    output vote_valid, vote_id, vote_val, out_ready,
    input  vote_ready, x_out, missing_mask, timed_out, out_valid, dup_err, bad_id,
           round_cnt, timeout_cnt
  );
  modport slave (
    input  vote_valid, vote_id, vote_val, out_ready,
    output vote_ready, x_out, missing_mask, timed_out, out_valid, dup_err, bad_id,
           round_cnt, timeout_cnt
  );
`else
  modport master (
    output vote_valid, vote_id, vote_val, out_ready,
    input  vote_ready, x_out, missing_mask, timed_out, out_valid, dup_err, bad_id
  );
  modport slave (
    input  vote_valid, vote_id, vote_val, out_ready,
    output vote_ready, x_out, missing_mask, timed_out, out_valid, dup_err, bad_id
  );
`endif

endinterface

// File: rtl/vote_round_timer.sv
// Saturating round timer; expired_c_o flags the edge on which the count reaches TIMEOUT_CYCLES.
module vote_round_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_c_o = en_i && !clr_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/vote_collector.sv
// Collects five voter bits in any order and presents them as one vector with a missing mask.
// Optional VOTE_COLLECTOR_STATS_EN adds saturating round and timeout counters.
module vote_collector
  import vote_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic        MISSING_VAL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  vote_collector_if.slave  vote_if
);

  localparam int unsigned VW = NUM_VOTERS;
  localparam logic [VW:1] FULL_MASK = '1;

  vote_state_t  state_q;
  logic [VW:1]  rcv_q, x_q, miss_q;
  logic         timed_out_q, out_valid_q, dup_q, bad_q;

  logic         vote_ready_c, accept_c, legal_c, seen_c, new_c, hs_c;
  logic         expired_c, tmr_clr_c, tmr_en_c;
  logic [VW:1]  id_oh_c, new_oh_c, rcv_d, x_d;

  // Decode the offered vote against the mask collected so far
  always_comb begin
    vote_ready_c = (state_q != PRESENT);
    accept_c     = vote_if.vote_valid && vote_ready_c;
    legal_c      = vote_id_legal(vote_if.vote_id);
    id_oh_c      = legal_c ? (VW'(1) << (vote_if.vote_id - 3'd1)) : '0;
    seen_c       = |(rcv_q & id_oh_c);
    new_c        = accept_c && legal_c && !seen_c;
    new_oh_c     = new_c ? id_oh_c : '0;
    rcv_d        = rcv_q | new_oh_c;
    x_d          = (x_q & ~new_oh_c) | (vote_if.vote_val ? new_oh_c : '0);
    hs_c         = out_valid_q && vote_if.out_ready;
    tmr_clr_c    = ((state_q == IDLE) && new_c) || hs_c;
    tmr_en_c     = (state_q == COLLECT);
  end

  vote_round_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (tmr_clr_c),
    .en_i        (tmr_en_c),
    .expired_c_o (expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rcv_q       <= '0;
      x_q         <= '0;
      miss_q      <= '0;
      timed_out_q <= 1'b0;
      out_valid_q <= 1'b0;
      dup_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      dup_q <= accept_c && legal_c && seen_c;
      bad_q <= accept_c && !legal_c;
      case (state_q)
        IDLE: begin
          rcv_q <= rcv_d;
          x_q   <= x_d;
          if (new_c) state_q <= COLLECT;
        end
        COLLECT: begin
          rcv_q <= rcv_d;
          // A completing vote beats a timeout on the same edge
          if (rcv_d == FULL_MASK) begin
            x_q         <= x_d;
            out_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end else if (expired_c) begin
            x_q         <= (x_d & rcv_d) | ({VW{MISSING_VAL}} & ~rcv_d);
            miss_q      <= ~rcv_d;
            timed_out_q <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end else begin
            x_q <= x_d;
          end
        end
        PRESENT: begin
          if (vote_if.out_ready) begin
            rcv_q       <= '0;
            miss_q      <= '0;
            timed_out_q <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vote_if.vote_ready   = vote_ready_c;
  assign vote_if.x_out        = x_q;
  assign vote_if.missing_mask = miss_q;
  assign vote_if.timed_out    = timed_out_q;
  assign vote_if.out_valid    = out_valid_q;
  assign vote_if.dup_err      = dup_q;
  assign vote_if.bad_id       = bad_q;

`ifdef VOTE_COLLECTOR_STATS_EN
  logic [15:0] round_cnt_q, timeout_cnt_q;

  // Saturating per-handshake statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else if (hs_c) begin
      if (round_cnt_q != 16'hFFFF) round_cnt_q <= round_cnt_q + 16'd1;
      if (timed_out_q && (timeout_cnt_q != 16'hFFFF)) timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign vote_if.round_cnt   = round_cnt_q;
  assign vote_if.timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: a default instance and a TIMEOUT_CYCLES=4 / MISSING_VAL=1 instance.
module tb_vote_collector;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vote_collector_if if_a ();
  vote_collector_if if_b ();

  vote_collector dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .vote_if (if_a)
  );

  vote_collector #(
    .TIMEOUT_CYCLES (4),
    .MISSING_VAL    (1'b1)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .vote_if (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [2:0] id, input logic val);
    if_a.vote_valid = v;
    if_a.vote_id    = id;
    if_a.vote_val   = val;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] id, input logic val);
    if_b.vote_valid = v;
    if_b.vote_id    = id;
    if_b.vote_val   = val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(1'b0, 3'd0, 1'b0);
    drive_b(1'b0, 3'd0, 1'b0);
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    cyc();
    cyc();
    checks++; if (if_a.x_out !== 5'b00000) begin errors++; $display("FAIL reset_x_out: got %b expected 00000", if_a.x_out); end
    checks++; if (if_a.missing_mask !== 5'b00000) begin errors++; $display("FAIL reset_missing: got %b expected 00000", if_a.missing_mask); end
    checks++; if (if_a.timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out: got %b expected 0", if_a.timed_out); end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if_a.out_valid); end
    checks++; if (if_a.dup_err !== 1'b0 || if_a.bad_id !== 1'b0) begin errors++; $display("FAIL reset_pulses: got dup=%b bad=%b expected 0 0", if_a.dup_err, if_a.bad_id); end
    checks++; if (if_a.vote_ready !== 1'b1) begin errors++; $display("FAIL reset_vote_ready: got %b expected 1", if_a.vote_ready); end
`ifdef VOTE_COLLECTOR_STATS_EN
    checks++; if (if_a.round_cnt !== 16'd0 || if_a.timeout_cnt !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d %0d expected 0 0", if_a.round_cnt, if_a.timeout_cnt); end
`endif
    rst_n = 1'b1;
    cyc();
  endtask

  // ids 5..1 with vals 1,0,1,1,0 -> x_out 5'b10110
  task automatic test_normal_round();
    logic [2:0] ids  [5] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    logic       vals [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    if_a.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, ids[k], vals[k]);
      cyc();
      if (k == 3) begin
        checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL normal_early_valid: got %b expected 0", if_a.out_valid); end
      end
    end
    drive_a(1'b0, 3'd0, 1'b0);
    checks++; if (if_a.out_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %b expected 1", if_a.out_valid); end
    checks++; if (if_a.x_out !== 5'b10110) begin errors++; $display("FAIL normal_x_out: got %b expected 10110", if_a.x_out); end
    checks++; if (if_a.missing_mask !== 5'b00000) begin errors++; $display("FAIL normal_missing: got %b expected 00000", if_a.missing_mask); end
    checks++; if (if_a.timed_out !== 1'b0) begin errors++; $display("FAIL normal_timed_out: got %b expected 0", if_a.timed_out); end
    checks++; if (if_a.vote_ready !== 1'b0) begin errors++; $display("FAIL normal_ready_present: got %b expected 0", if_a.vote_ready); end
    cyc();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL normal_valid_one_cycle: got %b expected 0", if_a.out_valid); end
    checks++; if (if_a.vote_ready !== 1'b1) begin errors++; $display("FAIL normal_ready_after: got %b expected 1", if_a.vote_ready); end
`ifdef VOTE_COLLECTOR_STATS_EN
    checks++; if (if_a.round_cnt !== 16'd1) begin errors++; $display("FAIL normal_round_cnt: got %0d expected 1", if_a.round_cnt); end
`endif
  endtask

  // ids 1 and 3 with val 0 on the short-timeout instance
  task automatic test_timeout();
    drive_b(1'b1, 3'd1, 1'b0);
    cyc();                                  // edge E
    drive_b(1'b1, 3'd3, 1'b0);
    cyc();                                  // E+1
    drive_b(1'b0, 3'd0, 1'b0);
    cyc();                                  // E+2
    cyc();                                  // E+3
    checks++; if (if_b.out_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0 at E+3", if_b.out_valid); end
    cyc();                                  // E+4
    checks++; if (if_b.out_valid !== 1'b1) begin errors++; $display("FAIL timeout_valid: got %b expected 1 at E+4", if_b.out_valid); end
    checks++; if (if_b.x_out !== 5'b11010) begin errors++; $display("FAIL timeout_x_out: got %b expected 11010", if_b.x_out); end
    checks++; if (if_b.missing_mask !== 5'b11010) begin errors++; $display("FAIL timeout_missing: got %b expected 11010", if_b.missing_mask); end
    checks++; if (if_b.timed_out !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", if_b.timed_out); end
    cyc();
    checks++; if (if_b.out_valid !== 1'b0 || if_b.timed_out !== 1'b0 || if_b.missing_mask !== 5'b00000) begin
      errors++; $display("FAIL timeout_clear: got valid=%b to=%b miss=%b expected 0 0 00000", if_b.out_valid, if_b.timed_out, if_b.missing_mask);
    end
`ifdef VOTE_COLLECTOR_STATS_EN
    checks++; if (if_b.timeout_cnt !== 16'd1) begin errors++; $display("FAIL timeout_cnt: got %0d expected 1", if_b.timeout_cnt); end
`endif
  endtask

  // id 2 twice (1 then 0), then 1,3,4,5 with val 0
  task automatic test_duplicate();
    if_a.out_ready = 1'b1;
    drive_a(1'b1, 3'd2, 1'b1);
    cyc();
    checks++; if (if_a.dup_err !== 1'b0) begin errors++; $display("FAIL dup_first: got %b expected 0", if_a.dup_err); end
    drive_a(1'b1, 3'd2, 1'b0);
    cyc();
    checks++; if (if_a.dup_err !== 1'b1) begin errors++; $display("FAIL dup_pulse: got %b expected 1", if_a.dup_err); end
    drive_a(1'b1, 3'd1, 1'b0);
    cyc();
    checks++; if (if_a.dup_err !== 1'b0) begin errors++; $display("FAIL dup_one_cycle: got %b expected 0", if_a.dup_err); end
    drive_a(1'b1, 3'd3, 1'b0); cyc();
    drive_a(1'b1, 3'd4, 1'b0); cyc();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL dup_not_complete: got %b expected 0", if_a.out_valid); end
    drive_a(1'b1, 3'd5, 1'b0); cyc();
    drive_a(1'b0, 3'd0, 1'b0);
    checks++; if (if_a.out_valid !== 1'b1 || if_a.timed_out !== 1'b0) begin errors++; $display("FAIL dup_complete: got valid=%b to=%b expected 1 0", if_a.out_valid, if_a.timed_out); end
    checks++; if (if_a.x_out !== 5'b00010) begin errors++; $display("FAIL dup_x_out: got %b expected 00010", if_a.x_out); end
    cyc();
  endtask

  // ids 0 and 7 mid-round on the short-timeout instance
  task automatic test_bad_id();
    int pulses;
    pulses = 0;
    drive_b(1'b1, 3'd1, 1'b1);
    cyc();                                  // E
    drive_b(1'b1, 3'd0, 1'b1);
    cyc();                                  // E+1
    if (if_b.bad_id === 1'b1) pulses++;
    drive_b(1'b1, 3'd7, 1'b0);
    cyc();                                  // E+2
    if (if_b.bad_id === 1'b1) pulses++;
    drive_b(1'b0, 3'd0, 1'b0);
    cyc();                                  // E+3
    if (if_b.bad_id === 1'b1) pulses++;
    checks++; if (if_b.out_valid !== 1'b0) begin errors++; $display("FAIL bad_early: got %b expected 0 at E+3", if_b.out_valid); end
    cyc();                                  // E+4
    if (if_b.bad_id === 1'b1) pulses++;
    checks++; if (pulses !== 2) begin errors++; $display("FAIL bad_pulses: got %0d expected 2", pulses); end
    checks++; if (if_b.out_valid !== 1'b1) begin errors++; $display("FAIL bad_timer: got %b expected 1 at E+4", if_b.out_valid); end
    checks++; if (if_b.missing_mask !== 5'b11110) begin errors++; $display("FAIL bad_mask: got %b expected 11110", if_b.missing_mask); end
    checks++; if (if_b.x_out !== 5'b11111) begin errors++; $display("FAIL bad_x_out: got %b expected 11111", if_b.x_out); end
    cyc();
  endtask

  // Hold out_ready low in PRESENT while a vote is offered
  task automatic test_backpressure();
    logic       vals [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    if_a.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, 3'(k + 1), vals[k]);
      cyc();
    end
    drive_a(1'b1, 3'd1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++; if (if_a.vote_ready !== 1'b0 || if_a.out_valid !== 1'b1 || if_a.x_out !== 5'b10011 || if_a.missing_mask !== 5'b00000) begin
        errors++; $display("FAIL bp_hold_%0d: got rdy=%b vld=%b x=%b miss=%b expected 0 1 10011 00000", c, if_a.vote_ready, if_a.out_valid, if_a.x_out, if_a.missing_mask);
      end
      cyc();
    end
    if_a.out_ready = 1'b1;
    cyc();                                  // handshake edge M
    checks++; if (if_a.out_valid !== 1'b0 || if_a.vote_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", if_a.out_valid, if_a.vote_ready); end
    cyc();                                  // M+1: held id1 val0 accepted
    checks++; if (if_a.dup_err !== 1'b0) begin errors++; $display("FAIL bp_first_accept: got dup=%b expected 0", if_a.dup_err); end
    drive_a(1'b1, 3'd1, 1'b1);
    cyc();
    checks++; if (if_a.dup_err !== 1'b1) begin errors++; $display("FAIL bp_second_dup: got dup=%b expected 1", if_a.dup_err); end
    for (int k = 2; k <= 5; k++) begin
      drive_a(1'b1, 3'(k), 1'b0);
      cyc();
    end
    drive_a(1'b0, 3'd0, 1'b0);
    checks++; if (if_a.out_valid !== 1'b1 || if_a.x_out !== 5'b00000) begin errors++; $display("FAIL bp_next_round: got vld=%b x=%b expected 1 00000", if_a.out_valid, if_a.x_out); end
    cyc();
  endtask

  // Reset mid-round, then a fresh complete round
  task automatic test_reset_mid_round();
    logic vals [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if_a.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive_a(1'b1, 3'(k), 1'b1);
      cyc();
    end
    drive_a(1'b0, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    checks++; if (if_a.out_valid !== 1'b0 || if_a.vote_ready !== 1'b1 || if_a.x_out !== 5'b00000) begin
      errors++; $display("FAIL rstmid_outputs: got vld=%b rdy=%b x=%b expected 0 1 00000", if_a.out_valid, if_a.vote_ready, if_a.x_out);
    end
    checks++; if (if_a.missing_mask !== 5'b00000 || if_a.timed_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got miss=%b to=%b expected 00000 0", if_a.missing_mask, if_a.timed_out);
    end
`ifdef VOTE_COLLECTOR_STATS_EN
    checks++; if (if_a.round_cnt !== 16'd0 || if_a.timeout_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stats: got %0d %0d expected 0 0", if_a.round_cnt, if_a.timeout_cnt); end
`endif
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, 3'(k + 1), vals[k]);
      cyc();
    end
    drive_a(1'b0, 3'd0, 1'b0);
    checks++; if (if_a.out_valid !== 1'b1 || if_a.missing_mask !== 5'b00000 || if_a.timed_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_fresh: got vld=%b miss=%b to=%b expected 1 00000 0", if_a.out_valid, if_a.missing_mask, if_a.timed_out);
    end
    checks++; if (if_a.x_out !== 5'b01010) begin errors++; $display("FAIL rstmid_x_out: got %b expected 01010", if_a.x_out); end
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal_round();
    test_timeout();
    test_duplicate();
    test_bad_id();
    test_backpressure();
    test_reset_mid_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_collector.md
# vote_collector

Upstream front end for the 5-input majority circuit. Accepts individual votes from five voters over a valid/ready handshake, in any order, and assembles them into one 5-bit vote vector. Presents the vector, with a per-voter missing mask, on a valid/ready output handshake that drives the majority circuit's `x[5:1]` input. A round-timeout substitutes a default value for voters that never report.

## Interface
- `TIMEOUT_CYCLES`, default 16: clock edges allowed after the first accepted vote of a round before the round is forced closed. Legal range ≥ 2.
- `MISSING_VAL`, default 1'b0: value substituted into `x_out` for each voter absent at timeout.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `vote_valid`  in  1  vote offered this cycle.
- `vote_id`  in  3  voter number; only 1..5 are legal.
- `vote_val`  in  1  the voter's bit.
- `vote_ready`  out  1  collector can accept a vote.
- `x_out`  out  5  `[5:1]`, assembled vector; bit i belongs to voter i.
- `missing_mask`  out  5  `[5:1]`; bit i = 1 means voter i was substituted.
- `timed_out`  out  1  round closed by timeout. Qualified by `out_valid`.
- `out_valid`  out  1  `x_out`, `missing_mask` and `timed_out` are valid.
- `out_ready`  in  1  downstream accepts.
- `dup_err`  out  1  one-cycle pulse: a duplicate vote was dropped.
- `bad_id`  out  1  one-cycle pulse: an illegal id was dropped.

## Operation
- States: IDLE (mask empty), COLLECT (1–4 votes held), PRESENT (`out_valid` = 1).
- `vote_ready` = 1 in IDLE and COLLECT, 0 in PRESENT. It is decoded from state, not registered.
- A vote is accepted when `vote_valid && vote_ready`.
  - Legal id, bit not yet received: set `rcv_mask[id]` and store `vote_val` in `x_out[id]`.
  - Legal id, already received: drop the vote; first vote wins. Pulse `dup_err`.
  - Illegal id (0, 6, 7): drop the vote and pulse `bad_id`. Mask and timer are unaffected.
- IDLE → COLLECT: on the first legal accept. The timer is cleared to 0 on that edge.
- COLLECT → PRESENT (normal close): on the accept that makes `rcv_mask` = 5'b11111.
  - `timed_out` = 0, `missing_mask` = 0.
- COLLECT → PRESENT (timeout close): the timer increments every edge in COLLECT. When it reaches `TIMEOUT_CYCLES` with the mask still incomplete:
  - `missing_mask` = ~`rcv_mask`.
  - Missing bits of `x_out` are set to `MISSING_VAL`.
  - `timed_out` = 1.
- Simultaneous completing vote and timeout on the same edge: normal close wins, `timed_out` = 0.
- A 5th vote that is a duplicate does not complete the round.
- PRESENT → IDLE: on the edge where `out_valid && out_ready`. On that edge, clear `rcv_mask`, `missing_mask`, `timed_out` and the timer.
  - `x_out` holds its last value. Only `rcv_mask` qualifies it.
- Outputs are stable while `out_valid && !out_ready`.
- Timer width: `$clog2(TIMEOUT_CYCLES+1)`. It never wraps; it saturates at `TIMEOUT_CYCLES`.

## Timing
- Reset values:
  - `x_out` = 0, `missing_mask` = 0, `timed_out` = 0, `out_valid` = 0.
  - `dup_err` = 0, `bad_id` = 0.
  - `vote_ready` = 1, state IDLE.
- Reset asserted mid-round discards the partial round immediately. No output is produced for it.
- Latency: if the completing vote is accepted on edge N, `out_valid` is high after edge N.
- Timeout: if the first vote is accepted on edge E, a forced close makes `out_valid` high after edge E + `TIMEOUT_CYCLES`.
- After the output is accepted on edge M, `vote_ready` is high in the cycle after M. A vote is accepted no earlier than edge M+1.
- `dup_err` and `bad_id` are registered. Each is high for exactly the cycle after the offending accept.

## Configuration
- `VOTE_COLLECTOR_STATS_EN` defined adds two outputs, both reset to 0:
  - `round_cnt[15:0]`: increments on every output handshake.
  - `timeout_cnt[15:0]`: increments on every handshake with `timed_out` = 1.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `vote_pkg`:
  - `NUM_VOTERS` = 5.
  - State enum `vote_state_t` {IDLE, COLLECT, PRESENT}.
  - Id legality function `vote_id_legal(id)` (true for 1..5).
- One sub-module: `vote_round_timer`. It contains the saturating timer, with clear, enable and an `expired` output.
- Everything else stays flat in `vote_collector`.

## Test plan
- Five votes, ids 5,4,3,2,1, vals 1,0,1,1,0 on consecutive edges, `out_ready` = 1:
  - `x_out` = 5'b10110, `missing_mask` = 0, `timed_out` = 0.
  - `out_valid` is high exactly one cycle, after the 5th accept.
- `TIMEOUT_CYCLES` = 4, `MISSING_VAL` = 1, only ids 1 and 3 with val 0:
  - `out_valid` rises after edge E+4.
  - `x_out` = 5'b11010, `missing_mask` = 5'b11010, `timed_out` = 1.
- Id 2 sent twice (vals 1 then 0), then ids 1,3,4,5:
  - `dup_err` pulses once.
  - `x_out[2]` = 1, round completes normally.
- Id 0 and id 7 offered mid-round:
  - `bad_id` pulses twice, mask unchanged, timer unaffected.
- Hold `out_ready` = 0 for 6 cycles in PRESENT while driving `vote_valid`:
  - `vote_ready` = 0 throughout and outputs are stable.
  - No vote is accepted until the cycle after the handshake.
- Assert `rst_n` low after 3 votes:
  - All outputs return to reset values.
  - The next 5 votes form a fresh round with `missing_mask` = 0.
  - With `VOTE_COLLECTOR_STATS_EN` defined, counters read 0 after reset.
